sort_stat_collector: RTL and testbench

Downstream consumer of the serial sorter output. Accepts the sorted serial stream one sample per handshake, groups every NUMBER samples into a frame, and captures frame statistics: min, upper median, max and sum. The result is presented as a single record on a valid/ready output, with an optional sortedness check. It sits directly after `serial_sort`, and its input port names mirror that block's output.

---
 rtl/sort_stat_collector.sv | 154 +++++++++++++++
 tb/tb_sort_stat_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stat_collector.sv
// sort_stat_collector
//   Consumes the sorted serial stream from serial_sort one sample per
//   valid/ready handshake. It groups every NUMBER samples into a frame and
//   reports index-0 (min), index NUMBER/2 (upper median), index NUMBER-1 (max)
//   and the sum of the frame as one record on a valid/ready output.
//
//   Optional feature macro: ORDER_CHECK_EN
//     defined   : err_o flags any frame in which a sample is below its predecessor
//     undefined : no ordering check, err_o is constant 0
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   valid_a  in   input sample valid
//   ready_a  out  input ready (registered)
//   data_i   in   input sample, WIDTH bits
//   valid_b  out  result record valid (registered)
//   ready_b  in   result record accepted
//   min_o    out  frame sample index 0
//   med_o    out  frame sample index NUMBER/2
//   max_o    out  frame sample index NUMBER-1
//   sum_o    out  unsigned frame sum, SW bits
//   err_o    out  frame ordering violation
module sort_stat_collector #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUMBER = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_a,
  output logic                                ready_a,
  input  logic [WIDTH-1:0]                    data_i,
  output logic                                valid_b,
  input  logic                                ready_b,
  output logic [WIDTH-1:0]                    min_o,
  output logic [WIDTH-1:0]                    med_o,
  output logic [WIDTH-1:0]                    max_o,
  output logic [WIDTH+$clog2(NUMBER)-1:0]     sum_o,
  output logic                                err_o
);

  localparam int unsigned SW = WIDTH + $clog2(NUMBER);
  localparam int unsigned CW = $clog2(NUMBER);
  localparam logic [CW-1:0] MED_IDX  = CW'(NUMBER / 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUMBER - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_REPORT  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_med;
  logic [SW-1:0]    r_sum;

  logic             w_accept;
  logic             w_first;
  logic [SW-1:0]    w_data_ext;
  logic [SW-1:0]    w_sum_next;
  logic [WIDTH-1:0] w_med_next;

  assign w_accept   = valid_a & ready_a;
  assign w_first    = (r_cnt == '0);
  assign w_data_ext = SW'(data_i);
  // First sample of a frame loads the accumulator instead of adding to it.
  assign w_sum_next = w_first ? w_data_ext : (r_sum + w_data_ext);
  // Forward the live sample when the median index is also the last index (NUMBER=2).
  assign w_med_next = (r_cnt == MED_IDX) ? data_i : r_med;

`ifdef ORDER_CHECK_EN
  logic [WIDTH-1:0] r_prev;
  logic             r_err;
  logic             w_err_next;

  // Sticky ordering flag; the first sample of a frame starts it clean.
  assign w_err_next = !w_first && (r_err || (data_i < r_prev));

  // Track previous sample and sticky violation across the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_err  <= 1'b0;
      err_o  <= 1'b0;
    end else if (r_state == S_COLLECT && w_accept) begin
      r_prev <= data_i;
      r_err  <= w_err_next;
      if (r_cnt == LAST_IDX) begin
        err_o <= w_err_next;
      end
    end
  end
`else
  assign err_o = 1'b0;
`endif

  // Frame collection / report FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
      r_cnt   <= '0;
      r_min   <= '0;
      r_med   <= '0;
      r_sum   <= '0;
      ready_a <= 1'b0;
      valid_b <= 1'b0;
      min_o   <= '0;
      med_o   <= '0;
      max_o   <= '0;
      sum_o   <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          ready_a <= 1'b1;
          if (w_accept) begin
            r_sum <= w_sum_next;
            r_med <= w_med_next;
            if (w_first) begin
              r_min <= data_i;
            end
            if (r_cnt == LAST_IDX) begin
              min_o   <= r_min;
              med_o   <= w_med_next;
              max_o   <= data_i;
              sum_o   <= w_sum_next;
              r_cnt   <= '0;
              r_state <= S_REPORT;
              valid_b <= 1'b1;
              ready_a <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_REPORT: begin
          ready_a <= 1'b0;
          valid_b <= 1'b1;
          if (ready_b) begin
            valid_b <= 1'b0;
            ready_a <= 1'b1;
            r_state <= S_COLLECT;
          end
        end
        default: begin
          r_state <= S_COLLECT;
          ready_a <= 1'b0;
          valid_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_stat_collector.sv
module tb_sort_stat_collector;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NUMBER = 16;
  localparam int unsigned SW     = WIDTH + $clog2(NUMBER);

  typedef struct {
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] md;
    logic [WIDTH-1:0] mx;
    logic [SW-1:0]    sm;
    logic             er;
  } rec_t;

  logic             clk;
  logic             rst_n;
  logic             valid_a;
  logic             ready_a;
  logic [WIDTH-1:0] data_i;
  logic             valid_b;
  logic             ready_b;
  logic [WIDTH-1:0] min_o;
  logic [WIDTH-1:0] med_o;
  logic [WIDTH-1:0] max_o;
  logic [SW-1:0]    sum_o;
  logic             err_o;

  int total;
  int bad;

  rec_t             exp_q[$];
  logic [WIDTH-1:0] fb[NUMBER];

  sort_stat_collector #(.WIDTH(WIDTH), .NUMBER(NUMBER)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_a(valid_a),
    .ready_a(ready_a),
    .data_i (data_i),
    .valid_b(valid_b),
    .ready_b(ready_b),
    .min_o  (min_o),
    .med_o  (med_o),
    .max_o  (max_o),
    .sum_o  (sum_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference record straight from the frame contents.
  function automatic rec_t model();
    rec_t r;
    int   s;
    s    = 0;
    r.er = 1'b0;
    for (int i = 0; i < int'(NUMBER); i++) begin
      s += int'(fb[i]);
`ifdef ORDER_CHECK_EN
      if (i > 0 && fb[i] < fb[i-1]) r.er = 1'b1;
`endif
    end
    r.mn = fb[0];
    r.md = fb[NUMBER/2];
    r.mx = fb[NUMBER-1];
    r.sm = SW'(s);
    return r;
  endfunction

  // Scoreboard monitor: pops on each new record, then checks it is held stable.
  logic have_rec;
  rec_t cur;
  initial have_rec = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_rec = 1'b0;
    end else if (valid_b) begin
      if (!have_rec) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_record actual=valid_b=1 required=no record at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
          have_rec = 1'b1;
          chk("rec_min", 32'(min_o), 32'(cur.mn));
          chk("rec_med", 32'(med_o), 32'(cur.md));
          chk("rec_max", 32'(max_o), 32'(cur.mx));
          chk("rec_sum", 32'(sum_o), 32'(cur.sm));
          chk("rec_err", 32'(err_o), 32'(cur.er));
        end
      end else begin
        chk("hold_min", 32'(min_o), 32'(cur.mn));
        chk("hold_sum", 32'(sum_o), 32'(cur.sm));
        chk("hold_ready_a", 32'(ready_a), 32'd0);
      end
      if (ready_b) have_rec = 1'b0;
    end
  end

  task automatic send_sample(input logic [WIDTH-1:0] d, input int bubble_max);
    int n;
    int b;
    b = (bubble_max > 0) ? int'($urandom_range(0, bubble_max)) : 0;
    valid_a = 1'b0;
    for (int i = 0; i < b; i++) begin
      @(posedge clk); #1;
    end
    valid_a = 1'b1;
    data_i  = d;
    n = 0;
    while (!ready_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_a) chk("ready_a_timeout", 32'(ready_a), 32'd1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    data_i  = WIDTH'($urandom);
  endtask

  // Pushes the model record, streams fb[], then checks 1-cycle result latency.
  task automatic send_frame(input int bubble_max);
    exp_q.push_back(model());
    for (int i = 0; i < int'(NUMBER); i++) send_sample(fb[i], bubble_max);
    chk("valid_b_latency", 32'(valid_b), 32'd1);
    chk("ready_a_low_in_report", 32'(ready_a), 32'd0);
  endtask

  task automatic handshake_one_cycle();
    @(posedge clk); #1;
    chk("valid_b_one_cycle", 32'(valid_b), 32'd0);
    chk("ready_a_after_hs", 32'(ready_a), 32'd1);
  endtask

  initial begin
    int stall;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    valid_a = 1'b0;
    data_i  = '0;
    ready_b = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    chk("rst_min", 32'(min_o), 32'd0);
    chk("rst_med", 32'(med_o), 32'd0);
    chk("rst_max", 32'(max_o), 32'd0);
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    chk("ready_a_still_low", 32'(ready_a), 32'd0);
    @(posedge clk); #1;
    chk("ready_a_after_rst", 32'(ready_a), 32'd1);

    // Ramp 0..15, back to back, ready_b high
    for (int i = 0; i < int'(NUMBER); i++) fb[i] = WIDTH'(i);
    send_frame(0);
    handshake_one_cycle();

    // All 255 with bubbles
    for (int i = 0; i < int'(NUMBER); i++) fb[i] = 8'd255;
    send_frame(3);
    handshake_one_cycle();

    // Stall in REPORT for 10 cycles with a driven but ignored valid_a
    for (int i = 0; i < int'(NUMBER); i++) fb[i] = WIDTH'(10 + 3 * i);
    ready_b = 1'b0;
    send_frame(1);
    for (int k = 0; k < 10; k++) begin
      valid_a = 1'b1;
      data_i  = WIDTH'($urandom);
      @(posedge clk); #1;
      chk("stall_valid_b", 32'(valid_b), 32'd1);
      chk("stall_ready_a", 32'(ready_a), 32'd0);
    end
    valid_a = 1'b0;
    ready_b = 1'b1;
    handshake_one_cycle();

    // Ordering violation then a clean frame
    for (int i = 0; i < int'(NUMBER); i++) fb[i] = WIDTH'(i);
    fb[5] = 8'd200;
    fb[6] = 8'd3;
    send_frame(0);
    handshake_one_cycle();
    for (int i = 0; i < int'(NUMBER); i++) fb[i] = WIDTH'(i);
    send_frame(0);
    handshake_one_cycle();

    // Reset after 7 accepts discards the partial frame
    for (int i = 0; i < 7; i++) send_sample(WIDTH'(100 + i), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_a", 32'(ready_a), 32'd0);
    chk("midrst_valid_b", 32'(valid_b), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < int'(NUMBER); i++) fb[i] = WIDTH'(16 + i);
    send_frame(0);
    handshake_one_cycle();

    // Random frames, mostly sorted, with random bubbles and stalls
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < int'(NUMBER); i++) fb[i] = WIDTH'($urandom);
      if ((f % 4) != 3) begin
        for (int i = 1; i < int'(NUMBER); i++) begin
          for (int j = i; j > 0 && fb[j] < fb[j-1]; j--) begin
            logic [WIDTH-1:0] t;
            t = fb[j]; fb[j] = fb[j-1]; fb[j-1] = t;
          end
        end
      end
      stall = int'($urandom_range(0, 4));
      ready_b = (stall == 0);
      send_frame(2);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        chk("rnd_stall_valid_b", 32'(valid_b), 32'd1);
      end
      ready_b = 1'b1;
      handshake_one_cycle();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
